// File: rtl/rf_pkg.sv
// rf_pkg: shared types and defaults for the rf_scb register file.
//   state_e        - clear-engine state (SWEEP zeroes the array, IDLE is normal operation)
//   DEF_DATA_W     - default register width
//   DEF_ADDR_W     - default address width (depth = 2^ADDR_W)
//   link_addr()    - default link register index for a given address width (top entry)
package rf_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    function automatic int link_addr(input int aw);
        return (1 << aw) - 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one busy bit per register for pipeline hazard detection.
//   i_clk, i_rst_n           - clock, asynchronous active-low reset
//   i_flush                  - hold every bit at 0 and mask the read taps
//   i_clr0_en/i_clr0_addr    - clear request from the general write port
//   i_clr1_en/i_clr1_addr    - clear request from the link write port
//   i_set_en/i_set_addr      - set request from issue (wins over a same-cycle clear)
//   i_rd_a, i_rd_b           - read tap addresses
//   o_busy_a, o_busy_b       - registered busy state at the tap addresses
module rf_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_clr0_en,
    input  logic [ADDR_W-1:0] i_clr0_addr,
    input  logic              i_clr1_en,
    input  logic [ADDR_W-1:0] i_clr1_addr,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic [ADDR_W-1:0] i_rd_a,
    input  logic [ADDR_W-1:0] i_rd_b,
    output logic              o_busy_a,
    output logic              o_busy_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;

    // Clears first, then set, so a register issued and written in the same
    // cycle stays busy for its new producer. Register 0 is never busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr0_en) w_busy_nxt[i_clr0_addr] = 1'b0;
        if (i_clr1_en) w_busy_nxt[i_clr1_addr] = 1'b0;
        if (i_set_en)  w_busy_nxt[i_set_addr]  = 1'b1;
        w_busy_nxt[0] = 1'b0;
        if (i_flush)   w_busy_nxt = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_busy <= '0;
        else          r_busy <= w_busy_nxt;
    end

    assign o_busy_a = ~i_flush & r_busy[i_rd_a];
    assign o_busy_b = ~i_flush & r_busy[i_rd_b];

endmodule

// File: rtl/rf_scb.sv
// rf_scb: register file with scoreboard and sweep-clear engine.
//   Clk, Rst_n          - clock, asynchronous active-low reset
//   Ra, Rb / busA, busB - combinational read ports (optional write bypass)
//   busyA, busyB        - scoreboard busy bits of Ra / Rb
//   WrEn, Rw, busW      - general write port
//   LinkWr, LinkPc      - link write port, stores {LinkPc, 2'b00} at LINK_REG
//   IssueEn, IssueRd    - mark destination register busy
//   ClrReq              - start a full-array clear sweep (ignored while sweeping)
//   Ready               - clear engine idle
//   DbgAddr, DbgData    - raw array debug read (no bypass)
module rf_scb
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LINK_REG = link_addr(ADDR_W),
    parameter bit BYPASS   = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    output logic              busyA,
    output logic              busyB,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] Rw,
    input  logic [DATA_W-1:0] busW,
    input  logic              LinkWr,
    input  logic [DATA_W-3:0] LinkPc,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] IssueRd,
    input  logic              ClrReq,
    output logic              Ready,
    input  logic [ADDR_W-1:0] DbgAddr,
    output logic [DATA_W-1:0] DbgData
);

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LP_LINK = ADDR_W'(LINK_REG);

    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic              w_sweep;
    logic              w_wr_gen, w_wr_link, w_issue;
    logic [DATA_W-1:0] w_link_val;
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Clear engine: state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= SWEEP;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Clear engine: next state
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            SWEEP: begin
                w_ptr_nxt = r_ptr + ADDR_W'(1);
                if (&r_ptr) w_state_nxt = IDLE;
            end
            IDLE: begin
                if (ClrReq) begin
                    w_state_nxt = SWEEP;
                    w_ptr_nxt   = '0;
                end
            end
            default: w_state_nxt = SWEEP;
        endcase
    end

    // Clear engine: outputs
    always_comb begin
        Ready   = (r_state == IDLE);
        w_sweep = (r_state == SWEEP);
    end

    // Register 0 is hardwired to zero, so writes aimed at it are dropped.
    assign w_link_val = {LinkPc, 2'b00};
    assign w_wr_gen   = Ready && WrEn && (Rw != '0);
    assign w_wr_link  = Ready && LinkWr && (LP_LINK != '0);
    assign w_issue    = Ready && IssueEn && (IssueRd != '0);

    // Link write is applied last so it wins a collision on LINK_REG.
    always_ff @(posedge Clk) begin
        if (w_sweep) begin
            r_mem[r_ptr] <= '0;
        end else begin
            if (w_wr_gen)  r_mem[Rw]      <= busW;
            if (w_wr_link) r_mem[LP_LINK] <= w_link_val;
        end
    end

    function automatic logic [DATA_W-1:0] rd_mux(input logic [ADDR_W-1:0] a);
        if (w_sweep || (a == '0))                      return '0;
        if (BYPASS && w_wr_link && (a == LP_LINK))     return w_link_val;
        if (BYPASS && w_wr_gen && (a == Rw))           return busW;
        return r_mem[a];
    endfunction

    always_comb begin
        busA    = rd_mux(Ra);
        busB    = rd_mux(Rb);
        DbgData = (DbgAddr == '0) ? '0 : r_mem[DbgAddr];
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scb (
        .i_clk       (Clk),
        .i_rst_n     (Rst_n),
        .i_flush     (w_sweep),
        .i_clr0_en   (w_wr_gen),
        .i_clr0_addr (Rw),
        .i_clr1_en   (w_wr_link),
        .i_clr1_addr (LP_LINK),
        .i_set_en    (w_issue),
        .i_set_addr  (IssueRd),
        .i_rd_a      (Ra),
        .i_rd_b      (Rb),
        .o_busy_a    (busyA),
        .o_busy_b    (busyB)
    );

endmodule

// File: doc/rf_scb.md
# rf_scb

Parametrised register file with scoreboard and sweep-clear engine, successor to the single-width 32×32 datapath register file. Provides two combinational read ports with optional same-cycle write bypass, a general write port plus a dedicated link-register write port, per-register busy bits for pipeline hazard detection, and a sequential clear engine that zeroes the array after reset or on request. Sits in the datapath between decode (reads and issue) and writeback (writes), with a debug read port for the board-level monitor.

## Interface
- DATA_W, 32, register width (≥ 3)
- ADDR_W, 5, address width; depth = 2^ADDR_W
- LINK_REG, 2^ADDR_W-1, index written by the link port
- BYPASS, 1, 1 = same-cycle write-to-read forwarding on busA/busB
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Ra, Rb  in  ADDR_W  read addresses
- busA, busB  out  DATA_W  read data
- busyA, busyB  out  1  scoreboard busy bit of Ra/Rb
- WrEn  in  1  general write enable
- Rw  in  ADDR_W  general write address
- busW  in  DATA_W  general write data
- LinkWr  in  1  link write enable
- LinkPc  in  DATA_W-2  link value; stored as {LinkPc, 2'b00}
- IssueEn  in  1  mark IssueRd busy
- IssueRd  in  ADDR_W  destination being issued
- ClrReq  in  1  request full array clear (pulse)
- Ready  out  1  high when the clear engine is idle
- DbgAddr  in  ADDR_W  debug read address
- DbgData  out  DATA_W  debug read data (raw array, no bypass)

## Operation
- Clear engine FSM, states SWEEP and IDLE. Reset → SWEEP, ptr=0. SWEEP: writes 0 to R[ptr] each cycle, ptr+1; after ptr = 2^ADDR_W-1 is written → IDLE. IDLE: ClrReq=1 → SWEEP, ptr=0. ClrReq during SWEEP is ignored.
- Ready = (state == IDLE). Ready=0 during reset and SWEEP.
- In SWEEP: WrEn, LinkWr, IssueEn ignored; busA=busB=0; busyA=busyB=0; all busy bits held at 0.
- Register 0: writes dropped, reads 0 on busA/busB/DbgData, never busy; IssueRd=0 ignored.
- Writes (IDLE only): WrEn → R[Rw]<=busW; LinkWr → R[LINK_REG]<={LinkPc,2'b00}. Both targeting LINK_REG in the same cycle: link write wins.
- Bypass (BYPASS=1, IDLE): busA = value being written this cycle to Ra (link value if the link write wins), else R[Ra]; same for busB. BYPASS=0: reads return the array only.
- Scoreboard: at each edge, a write (either port) clears busy[target]; IssueEn sets busy[IssueRd]. Same register issued and written in one cycle → busy stays 1 (new producer). busyA/busyB = busy[Ra]/busy[Rb] registered state, not bypassed.
- Array has no reset; contents are defined only after the first sweep completes.

## Timing
- Reset values: state=SWEEP, ptr=0, all busy=0, Ready=0, busA=busB=0, busyA=busyB=0.
- Sweep after reset or ClrReq: 2^ADDR_W cycles (32 at default); Ready rises on the edge that writes the last entry. ClrReq in IDLE: Ready falls on the next edge.
- Read latency 0 (combinational). Write visible in the array on the next cycle; visible on busA/busB the same cycle with BYPASS=1.
- Busy set/clear visible the cycle after the edge.
- Rst_n asserted mid-sweep or mid-operation: immediate abort, busy cleared, sweep restarts at ptr=0 on release.

## Structure
- Package rf_pkg: state enum {SWEEP, IDLE}, default parameter constants, link-address helper function.
- Sub-module rf_scoreboard: busy-bit vector with set/clear/flush and two read taps; the top holds the array, bypass muxes and clear FSM.

## Test plan
- Reset release → Ready low exactly 32 cycles, then high; DbgData at every address = 0.
- WrEn Rw=5 busW=0xDEADBEEF, Ra=5 same cycle → busA=0xDEADBEEF (BYPASS=1); next cycle DbgData(5)=0xDEADBEEF; with BYPASS=0 same-cycle busA shows the old value.
- WrEn Rw=31 busW=0x1111 with LinkWr LinkPc=0x100 → R31=0x400; write to Rw=0 → busA(Ra=0)=0.
- IssueEn IssueRd=7 → busyA(Ra=7)=1 next cycle; same-cycle IssueEn 7 and WrEn 7 → busy stays 1; later WrEn 7 alone → busy 0.
- ClrReq after loading R1..R31 → Ready=0, writes ignored, busA=0 during sweep; after 32 cycles all 0, Ready=1.
- Rst_n pulsed at sweep ptr=10 → busy flushed, sweep restarts, Ready after a full 32 cycles.
